// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO owner for the EXE stage. It runs a fixed-latency
// multiplier or a 32-step restoring divider, holds the pipeline while it
// runs, and then commits the result to HI/LO. A flush cancels any operation
// that has not yet committed.
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_type,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);

  state_t      state, next_state;
  logic [4:0]  cnt;
  logic [31:0] a_q, b_q;      // operands as issued, used for the sign fix-up
  logic        sgn_q;         // 1 for MULT/DIV
  logic [31:0] rem_q, quo_q;  // divider partial remainder / quotient shifter
  logic [31:0] dvs_q;         // divisor magnitude

  logic start_mul, start_div, wr_mthi, wr_mtlo, commit_mul, commit_div;
  logic is_muldiv;

  // Multiplier: both operands extended to 64 bits; the low 64 bits of that
  // product equal the 33x33 signed/unsigned product.
  logic [63:0] mul_a, mul_b, prod;

  // Divider datapath: one restoring step per cycle.
  logic [32:0] rem_shift, diff;
  logic        step_ok;
  logic [31:0] rem_nxt, quo_nxt, q_fix, r_fix;
  logic [31:0] src_a_mag, src_b_mag;
  logic        src_signed;

  assign src_signed = ~op_type[0];
  assign src_a_mag  = (src_signed && src_a[31]) ? -src_a : src_a;
  assign src_b_mag  = (src_signed && src_b[31]) ? -src_b : src_b;

  assign mul_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign step_ok   = ~diff[32];
  assign rem_nxt   = step_ok ? diff[31:0] : rem_shift[31:0];
  assign quo_nxt   = {quo_q[30:0], step_ok};
  assign q_fix     = (sgn_q && (a_q[31] ^ b_q[31])) ? -quo_nxt : quo_nxt;
  assign r_fix     = (sgn_q && a_q[31]) ? -rem_nxt : rem_nxt;

  assign is_muldiv = (op_type == OP_MULT) || (op_type == OP_MULTU) ||
                     (op_type == OP_DIV)  || (op_type == OP_DIVU);

  // Stall is combinational so the accept cycle already holds the pipeline.
  assign stall_req = rst & ~flush &
                     (((state == S_IDLE) & op_valid & is_muldiv) |
                      (state == S_MUL) | (state == S_DIV));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state and one-cycle control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    next_state = state;
    start_mul  = 1'b0;
    start_div  = 1'b0;
    wr_mthi    = 1'b0;
    wr_mtlo    = 1'b0;
    commit_mul = 1'b0;
    commit_div = 1'b0;
    case (state)
      S_IDLE: begin
        if (op_valid && !flush) begin
          case (op_type)
            OP_MULT, OP_MULTU: begin start_mul = 1'b1; next_state = S_MUL; end
            OP_DIV, OP_DIVU:   begin start_div = 1'b1; next_state = S_DIV; end
            OP_MTHI:           wr_mthi = 1'b1;
            OP_MTLO:           wr_mtlo = 1'b1;
            default:           ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) next_state = S_IDLE;
        else if (cnt == 5'd0) begin
          commit_mul = 1'b1;
          next_state = S_DONE;
        end
      end
      S_DIV: begin
        if (flush) next_state = S_IDLE;
        else if (cnt == 5'd0) begin
          // A zero divisor still completes, but leaves HI/LO untouched.
          commit_div = (dvs_q != 32'd0);
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand latches, step counter, divider shifter, HI/LO and status flops.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well, so HI/LO and the divider
    // come out of reset with known contents rather than X.
    if (!rst) begin
      cnt    <= 5'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      sgn_q  <= 1'b0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
      hi_out <= 32'd0;
      lo_out <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (start_mul || start_div) begin
        a_q   <= src_a;
        b_q   <= src_b;
        sgn_q <= src_signed;
      end

      if (start_mul)                             cnt <= MUL_CNT_INIT;
      else if (start_div)                        cnt <= 5'd31;
      else if (state == S_MUL || state == S_DIV) cnt <= cnt - 5'd1;

      if (start_div) begin
        rem_q <= 32'd0;
        quo_q <= src_a_mag;
        dvs_q <= src_b_mag;
      end else if (state == S_DIV) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
      end

      if (wr_mthi) hi_out <= src_a;
      if (wr_mtlo) lo_out <= src_a;
      if (commit_mul) begin
        hi_out <= prod[63:32];
        lo_out <= prod[31:0];
      end
      if (commit_div) begin
        hi_out <= r_fix;
        lo_out <= q_fix;
      end

      busy <= (next_state == S_MUL) || (next_state == S_DIV);
      done <= (next_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl. Expected HI/LO pairs are pushed to a
// scoreboard queue when an operation is issued and popped on its done pulse.
module tb_hilo_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  logic        clk, rst, op_valid, flush;
  logic [2:0]  op_type;
  logic [31:0] src_a, src_b;
  logic        stall_req, busy, done;
  logic [31:0] hi_out, lo_out;

  int          n_pass   = 0;
  int          n_checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
    .src_a(src_a), .src_b(src_b), .flush(flush), .stall_req(stall_req),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference results from native arithmetic: {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] t, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              q, r;
    case (t)
      MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      MULTU: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        return up;
      end
      DIV: begin
        if (b == 32'd0) return {m_hi, m_lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {m_hi, m_lo};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic start_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    cycle();
    op_valid = 1'b1;
    op_type  = t;
    src_a    = a;
    src_b    = b;
  endtask

  // Issue a mul/div, hold it in EXE until done, and score it. Returns at the
  // negative edge of the DONE cycle with op_valid still high.
  task automatic run_op(input string tag, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_hilo);
    int          stalls = 0;
    int          cyc    = 0;
    bit          got    = 1'b0;
    int          lat;
    logic [63:0] e;
    lat = (t == MULT || t == MULTU) ? MUL_LAT + 1 : 33;
    exp_q.push_back(exp_hilo);
    start_op(t, a, b);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        cyc = c;
        break;
      end
      if (stall_req) stalls++;
      cycle();
    end
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, got, 1);
    if (got) begin
      check({tag, "_done_cycle"}, cyc, lat);
      check({tag, "_stall_cycles"}, stalls, lat);
      check({tag, "_stall_in_done"}, stall_req, 0);
      check({tag, "_hi"}, hi_out, e[63:32]);
      check({tag, "_lo"}, lo_out, e[31:0]);
    end
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  // Instruction leaves EXE; the controller must be idle and not restarted.
  task automatic release_op(input string tag);
    cycle();
    op_valid = 1'b0;
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_stall"}, stall_req, 0);
  endtask

  task automatic mt(input string tag, input bit to_hi, input logic [31:0] v);
    start_op(to_hi ? MTHI : MTLO, v, 32'd0);
    @(negedge clk);
    check({tag, "_stall"}, stall_req, 0);
    check({tag, "_busy"}, busy, 0);
    cycle();
    op_valid = 1'b0;
    @(negedge clk);
    if (to_hi) m_hi = v;
    else       m_lo = v;
    check({tag, "_hi"}, hi_out, m_hi);
    check({tag, "_lo"}, lo_out, m_lo);
  endtask

  initial begin
    logic [2:0]  t;
    logic [31:0] ra, rb;

    rst      = 1'b0;
    flush    = 1'b0;
    op_valid = 1'b1;
    op_type  = MULT;
    src_a    = 32'd3;
    src_b    = 32'd4;
    m_hi     = 32'd0;
    m_lo     = 32'd0;

    // Reset state, with a mul request present to prove stall is suppressed.
    repeat (3) cycle();
    @(negedge clk);
    check("rst_stall", stall_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    cycle();
    rst      = 1'b1;
    op_valid = 1'b0;

    // Multiply.
    run_op("mult", MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    release_op("mult");
    run_op("multu", MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA);
    release_op("multu");

    // Divide.
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    release_op("div_neg");
    run_op("divu", DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    release_op("divu");
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    release_op("div_ovf");

    // Divide by zero keeps preset HI/LO.
    mt("mthi", 1'b1, 32'h11);
    mt("mtlo", 1'b0, 32'h22);
    run_op("divz", DIVU, 32'd5, 32'd0, 64'h0000_0011_0000_0022);
    release_op("divz");

    // Flush in DIV cycle 10.
    start_op(DIV, 32'd1000, 32'd3);
    repeat (10) cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_div_stall", stall_req, 0);
    cycle();
    flush    = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    check("flush_div_busy", busy, 0);
    check("flush_div_done", done, 0);
    check("flush_div_hi", hi_out, 32'h11);
    check("flush_div_lo", lo_out, 32'h22);
    run_op("mult_after_flush", MULT, 32'h10, 32'h20, 64'h0000_0000_0000_0200);
    release_op("mult_after_flush");

    // Flush in the final MUL cycle.
    start_op(MULT, 32'd5, 32'd7);
    repeat (MUL_LAT) cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_mul_stall", stall_req, 0);
    cycle();
    flush    = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    check("flush_mul_done", done, 0);
    check("flush_mul_busy", busy, 0);
    cycle();
    @(negedge clk);
    check("flush_mul_hi", hi_out, 32'h0);
    check("flush_mul_lo", lo_out, 32'h200);

    // Back-to-back: DIVU held through DONE, then MTLO right after.
    run_op("divu_hold", DIVU, 32'd1000, 32'd10, 64'h0000_0000_0000_0064);
    mt("mtlo_b2b", 1'b0, 32'hABCD);

    // A few random operations scored against native arithmetic.
    for (int i = 0; i < 8; i++) begin
      t  = 3'(i % 4);
      ra = $urandom;
      rb = $urandom;
      if (t[1] && rb == 32'd0) rb = 32'd9;
      run_op($sformatf("rand%0d", i), t, ra, rb, model(t, ra, rb));
      release_op($sformatf("rand%0d", i));
    end

    // Reset during DIV cycle 20.
    start_op(DIV, 32'h1234_5678, 32'h55);
    repeat (20) cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_div_stall_low", stall_req, 0);
    cycle();
    rst      = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    check("rst_div_hi", hi_out, 0);
    check("rst_div_lo", lo_out, 0);
    check("rst_div_busy", busy, 0);
    check("rst_div_stall", stall_req, 0);
    check("rst_div_done", done, 0);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
